// File: rtl/rv32_tb_pkg.sv
// Shared constants and checker FSM encoding for the RV32 test harness blocks
// (sram, exec, halt_sum_checker).
package rv32_tb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REF,
        ST_CMP,
        ST_DONE
    } chk_state_t;

endpackage

// File: rtl/halt_sum_checker.sv
// End-of-test checker: on halt, sums NUM_WORDS SRAM words and compares the sum
// minus SUM_BIAS to a reference word. Optional watchdog under CHECK_TIMEOUT_EN.
module halt_sum_checker
    import rv32_tb_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned REF_ADDR    = 16,
    parameter int unsigned SUM_BIAS    = 1,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] sum_out,
    output logic [DATA_W-1:0] ref_out,
    output logic              timeout
);

    chk_state_t        state, state_nxt;
    logic              halted_q;
    logic [DATA_W-1:0] acc;
    logic [31:0]       idx;
    logic [DATA_W-1:0] sum_r;
    logic [DATA_W-1:0] ref_r;
    logic              pass_r;
    logic              start;
    logic              last_word;
    logic              to_hit;
    logic [DATA_W-1:0] biased;

    assign start     = halted && !halted_q;
    assign last_word = (idx == 32'(NUM_WORDS - 1));
    assign biased    = acc - DATA_W'(SUM_BIAS);

`ifdef CHECK_TIMEOUT_EN
    logic [31:0] cyc_cnt;
    logic        timeout_r;

    assign to_hit  = (state != ST_DONE) && (cyc_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout = timeout_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            timeout_r <= 1'b0;
        end else if (state != ST_DONE) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (to_hit)
                timeout_r <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign to_hit             = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = (NUM_WORDS == 0) ? ST_REF : ST_SCAN;
            ST_SCAN: if (mem_rvalid && last_word) state_nxt = ST_REF;
            ST_REF:  if (mem_rvalid) state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (to_hit)
            state_nxt = ST_DONE;
    end

    // Request is a pure decode of the state register so an async reset drops it at once.
    always_comb begin
        mem_req  = (state == ST_SCAN) || (state == ST_REF);
        mem_addr = (state == ST_REF) ? ADDR_W'(REF_ADDR) : ADDR_W'(BASE_ADDR + idx);
        busy     = (state == ST_SCAN) || (state == ST_REF) || (state == ST_CMP);
        done     = (state == ST_DONE);
        pass     = pass_r;
        sum_out  = sum_r;
        ref_out  = ref_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            halted_q <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            sum_r    <= '0;
            ref_r    <= '0;
            pass_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            halted_q <= halted;
            if (state == ST_SCAN && mem_rvalid) begin
                acc <= acc + mem_rdata;
                idx <= idx + 32'd1;
            end
            if (state == ST_REF && mem_rvalid)
                ref_r <= mem_rdata;
            // A watchdog hit during CMP must leave pass low.
            if (state == ST_CMP && !to_hit) begin
                sum_r  <= biased;
                pass_r <= (biased == ref_r);
            end
        end
    end

endmodule

// File: tb/tb_halt_sum_checker.sv
// Scoreboard bench for halt_sum_checker with a behavioural SRAM read port
// (zero-wait or random 0-3 cycle latency).
module tb_halt_sum_checker;

`ifdef CHECK_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 50;
`else
    localparam int unsigned TB_TIMEOUT = 100000;
`endif

    typedef struct packed {
        logic        pass;
        logic [31:0] sum;
        logic [31:0] refv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] sum_out;
    logic [31:0] ref_out;
    logic        timeout;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic [31:0] mem [1024];
    bit          rand_delay = 0;
    bit          addr_bad   = 0;
    bit          pend       = 0;
    int          wcnt;
    int          dly;
    logic [9:0]  paddr;
    logic        rvalid_r = 1'b0;
    logic [31:0] rdata_r  = '0;

    always #5 clk = ~clk;

    halt_sum_checker #(
        .DATA_W      (32),
        .ADDR_W      (10),
        .BASE_ADDR   (0),
        .NUM_WORDS   (16),
        .REF_ADDR    (16),
        .SUM_BIAS    (1),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halted     (halted),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sum_out    (sum_out),
        .ref_out    (ref_out),
        .timeout    (timeout)
    );

    assign mem_rvalid = rvalid_r;
    assign mem_rdata  = rdata_r;

    // SRAM model: accepts a request when idle, answers after 0..3 extra cycles.
    always @(posedge clk) begin
        if (rst) begin
            pend = 0;
            rvalid_r <= 1'b0;
        end else if (pend) begin
            if (!mem_req || mem_addr !== paddr)
                addr_bad = 1;
            if (wcnt == 0) begin
                rvalid_r <= 1'b1;
                rdata_r  <= mem[paddr];
                pend = 0;
            end else begin
                wcnt--;
                rvalid_r <= 1'b0;
            end
        end else if (mem_req && !rvalid_r) begin
            dly   = rand_delay ? int'($urandom_range(0, 3)) : 0;
            paddr = mem_addr;
            if (dly == 0) begin
                rvalid_r <= 1'b1;
                rdata_r  <= mem[mem_addr];
            end else begin
                pend = 1;
                wcnt = dly - 1;
                rvalid_r <= 1'b0;
            end
        end else begin
            rvalid_r <= 1'b0;
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        halted = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_mem(input logic [31:0] base, input logic [31:0] step, input logic [31:0] refv);
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = base + step * 32'(i);
        mem[16] = refv;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int reqc);
        ok   = 0;
        reqc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_req) reqc++;
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_scan(input bit glitch, output bit ok, output int reqc);
        do_reset();
        halted = 1'b1;
        if (glitch) begin
            repeat (5) @(negedge clk);
            halted = 1'b0;
            repeat (2) @(negedge clk);
            halted = 1'b1;
        end
        wait_done(400, ok, reqc);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        halted = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_req, busy, done, pass, timeout, sum_out, ref_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b busy=%b done=%b pass=%b to=%b sum=%h ref=%h, expected all 0",
                     mem_req, busy, done, pass, timeout, sum_out, ref_out);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({mem_req, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_no_halt: got req=%b busy=%b done=%b, expected 000", mem_req, busy, done);
        end
    endtask

    task automatic test_sum_pass();
        exp_t e;
        bit   ok;
        int   rc;
        load_mem(32'd1, 32'd1, 32'd135);
        sb.push_back('{pass: 1'b1, sum: 32'd135, refv: 32'd135});
        run_scan(0, ok, rc);
        e = sb.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL pass_done: done=%b, expected 1 within 400 cycles", done);
        end
        n_tests++;
        if ({pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL pass_result: got pass=%b sum=%h ref=%h, expected pass=%b sum=%h ref=%h",
                     pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
        n_tests++;
        if (rc != 34 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_timing: got req_cycles=%0d busy=%b, expected 34 and 0", rc, busy);
        end
    endtask

    task automatic test_sum_fail();
        exp_t e;
        bit   ok;
        int   rc;
        load_mem(32'd1, 32'd1, 32'd136);
        sb.push_back('{pass: 1'b0, sum: 32'd135, refv: 32'd136});
        run_scan(0, ok, rc);
        e = sb.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fail_done: done=%b, expected 1", done);
        end
        n_tests++;
        if ({pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL fail_result: got pass=%b sum=%h ref=%h, expected pass=%b sum=%h ref=%h",
                     pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   ok;
        int   rc;
        load_mem(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFEF);
        sb.push_back('{pass: 1'b1, sum: 32'hFFFF_FFEF, refv: 32'hFFFF_FFEF});
        run_scan(1, ok, rc);
        e = sb.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b, expected 1", done);
        end
        n_tests++;
        if ({pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL wrap_result: got pass=%b sum=%h ref=%h, expected pass=%b sum=%h ref=%h",
                     pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
    endtask

    task automatic test_random_delay();
        exp_t e;
        bit   ok;
        int   rc;
        load_mem(32'd1, 32'd1, 32'd135);
        sb.push_back('{pass: 1'b1, sum: 32'd135, refv: 32'd135});
        rand_delay = 1;
        addr_bad   = 0;
        run_scan(0, ok, rc);
        rand_delay = 0;
        e = sb.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_done: done=%b, expected 1", done);
        end
        n_tests++;
        if ({pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL rand_result: got pass=%b sum=%h ref=%h, expected pass=%b sum=%h ref=%h",
                     pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
        n_tests++;
        if (addr_bad) begin
            n_fail++;
            $display("FAIL rand_addr_stable: got addr_changed=%b, expected 0", addr_bad);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        bit   found;
        bit   ok;
        int   rc;
        load_mem(32'd1, 32'd1, 32'd135);
        sb.push_back('{pass: 1'b1, sum: 32'd135, refv: 32'd135});
        do_reset();
        halted = 1'b1;
        found  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 10'd7) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrst_reach_idx7: got addr=%h req=%b, expected req at addr 007", mem_addr, mem_req);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_async_drop: got req=%b busy=%b, expected 00", mem_req, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(400, ok, rc);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL midrst_rerun: got done=%b pass=%b sum=%h ref=%h, expected done=1 pass=%b sum=%h ref=%h",
                     done, pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
    endtask

    task automatic test_halt_ignored();
        exp_t e;
        bit   ok;
        int   rc;
        int   bad;
        load_mem(32'd10, 32'd3, 32'd519);
        sb.push_back('{pass: 1'b1, sum: 32'd519, refv: 32'd519});
        run_scan(0, ok, rc);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            halted = i[1];
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        e = sb.pop_front();
        n_tests++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL rehalt_sticky: got ok=%b bad_cycles=%0d, expected ok=1 bad_cycles=0", ok, bad);
        end
        n_tests++;
        if ({pass, sum_out, ref_out} !== e) begin
            n_fail++;
            $display("FAIL rehalt_result: got pass=%b sum=%h ref=%h, expected pass=%b sum=%h ref=%h",
                     pass, sum_out, ref_out, e.pass, e.sum, e.refv);
        end
    endtask

`ifdef CHECK_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        repeat (49) @(negedge clk);
        n_tests++;
        if ({timeout, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_early: got timeout=%b done=%b at cycle 49, expected 00", timeout, done);
        end
        @(negedge clk);
        n_tests++;
        if ({timeout, done, pass, mem_req} !== 4'b1100) begin
            n_fail++;
            $display("FAIL timeout_fire: got timeout=%b done=%b pass=%b req=%b at cycle 50, expected 1100",
                     timeout, done, pass, mem_req);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        halted = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
`ifdef CHECK_TIMEOUT_EN
        test_timeout();
`else
        test_sum_pass();
        test_sum_fail();
        test_wrap();
        test_random_delay();
        test_reset_mid_scan();
        test_halt_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation exceeded 500000 time units, expected completion");
        $fatal(1);
    end

endmodule
